// File: rtl/eeprom_page_sched_pkg.sv
// Shared constants for the EEPROM page-write scheduler: FSM encodings,
// SPI EEPROM opcodes and the page-alignment helper.
package eeprom_page_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WREN     = 4'd1,
    ST_CS_GAP   = 4'd2,
    ST_WRITE    = 4'd3,
    ST_ADDR_H   = 4'd4,
    ST_ADDR_L   = 4'd5,
    ST_DATA     = 4'd6,
    ST_POLL_CMD = 4'd7,
    ST_POLL_RD  = 4'd8,
    ST_CHECK    = 4'd9,
    ST_DONE     = 4'd10
  } state_t;

  // Per-byte handshake phase inside a byte-carrying state.
  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,  // nCS already low, first byte not yet started
    PH_FETCH = 2'd1,  // data_rd issued, requester presents byte next cycle
    PH_ISSUE = 2'd2,  // spi_start as soon as the engine is idle
    PH_WAIT  = 2'd3   // byte outstanding, waiting for busy to fall
  } phase_t;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_DUMMY = 8'h00;

  // Clear the in-page offset bits so the write starts on a page boundary.
  function automatic logic [15:0] page_align(input logic [15:0] a, input int unsigned page_bytes);
    return a & ~(16'(page_bytes - 32'd1));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The requester not granted last wins a
// tie; last-grant resets to requester 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       owner,
  output logic [1:0] pick
);

  logic last;

  // Remember which requester completed most recently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b1;
    end else if (update) begin
      last <= owner;
    end else begin
      last <= last;
    end
  end

  // One-hot pick of the winning requester.
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/eeprom_page_sched.sv
// EEPROM page-write scheduler: arbitrates two requesters and drives one SPI
// page program (WREN, WRITE+address+data, RDSR polling) through a byte engine.
module eeprom_page_sched
  import eeprom_page_sched_pkg::*;
#(
  parameter int PAGE_BYTES = 32,
  parameter int POLL_MAX   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  data_in0,
  input  logic [7:0]  data_in1,
  output logic        data_rd,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic        timeout,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_busy,
  input  logic [7:0]  spi_rx,
  output logic        nCS
);

  localparam int PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [8:0]    BYTE_LAST = 9'(PAGE_BYTES - 1);

  state_t        state, state_nxt, gap_target, gap_target_nxt;
  phase_t        phase, phase_nxt;
  logic          gap_cnt, gap_cnt_nxt;
  logic [8:0]    byte_cnt, byte_cnt_nxt;
  logic [PW-1:0] poll_cnt, poll_cnt_nxt;
  logic          busy_seen, busy_seen_nxt;
  logic          owner, owner_nxt;
  logic [15:0]   page_addr, page_addr_nxt;
  logic          wip, wip_nxt;
  logic          ncs_nxt, data_rd_nxt, timeout_nxt;
  logic [1:0]    grant_nxt, done_nxt;
  logic [1:0]    pick;
  logic          arb_update;
  logic          is_byte, byte_done;
  logic [7:0]    data_sel;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (arb_update),
    .owner  (owner),
    .pick   (pick)
  );

  assign is_byte   = state inside {ST_WREN, ST_WRITE, ST_ADDR_H, ST_ADDR_L,
                                   ST_DATA, ST_POLL_CMD, ST_POLL_RD};
  // A byte completes on the first idle cycle after the engine reported busy.
  assign byte_done = is_byte && (phase == PH_WAIT) && busy_seen && !spi_busy;
  assign data_sel  = owner ? data_in1 : data_in0;

  // Byte to transmit in the current state; data bytes come straight from the
  // owner so the byte fetched by data_rd goes out on the following cycle.
  always_comb begin
    spi_tx = 8'h00;
    case (state)
      ST_WREN:     spi_tx = OP_WREN;
      ST_WRITE:    spi_tx = OP_WRITE;
      ST_ADDR_H:   spi_tx = page_addr[15:8];
      ST_ADDR_L:   spi_tx = page_addr[7:0];
      ST_DATA:     spi_tx = data_sel;
      ST_POLL_CMD: spi_tx = OP_RDSR;
      ST_POLL_RD:  spi_tx = OP_DUMMY;
      default:     spi_tx = 8'h00;
    endcase
  end

  // Next-state, byte handshake and next values of the registered outputs.
  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    gap_cnt_nxt    = gap_cnt;
    gap_target_nxt = gap_target;
    byte_cnt_nxt   = byte_cnt;
    poll_cnt_nxt   = poll_cnt;
    busy_seen_nxt  = busy_seen;
    owner_nxt      = owner;
    page_addr_nxt  = page_addr;
    wip_nxt        = wip;
    ncs_nxt        = nCS;
    grant_nxt      = grant;
    done_nxt       = 2'b00;
    timeout_nxt    = 1'b0;
    data_rd_nxt    = 1'b0;
    spi_start      = 1'b0;
    arb_update     = 1'b0;

    if (is_byte) begin
      case (phase)
        PH_SETUP, PH_FETCH: phase_nxt = PH_ISSUE;
        PH_ISSUE: begin
          if (!spi_busy) begin
            spi_start     = 1'b1;
            phase_nxt     = PH_WAIT;
            busy_seen_nxt = 1'b0;
          end else begin
            phase_nxt = PH_ISSUE;
          end
        end
        PH_WAIT:  busy_seen_nxt = busy_seen | spi_busy;
        default:  phase_nxt = PH_ISSUE;
      endcase
    end else begin
      busy_seen_nxt = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt     = ST_WREN;
          phase_nxt     = PH_SETUP;
          grant_nxt     = pick;
          owner_nxt     = pick[1];
          page_addr_nxt = page_align(pick[1] ? addr1 : addr0, PAGE_BYTES);
          ncs_nxt       = 1'b0;
          byte_cnt_nxt  = 9'd0;
          poll_cnt_nxt  = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WREN: begin
        if (byte_done) begin
          state_nxt      = ST_CS_GAP;
          gap_cnt_nxt    = 1'b0;
          gap_target_nxt = ST_WRITE;
          ncs_nxt        = 1'b1;
        end else begin
          state_nxt = ST_WREN;
        end
      end
      ST_CS_GAP: begin
        if (gap_cnt) begin
          state_nxt = gap_target;
          phase_nxt = PH_SETUP;
          ncs_nxt   = 1'b0;
        end else begin
          gap_cnt_nxt = 1'b1;
        end
      end
      ST_WRITE: begin
        if (byte_done) begin
          state_nxt = ST_ADDR_H;
          phase_nxt = PH_ISSUE;
        end else begin
          state_nxt = ST_WRITE;
        end
      end
      ST_ADDR_H: begin
        if (byte_done) begin
          state_nxt = ST_ADDR_L;
          phase_nxt = PH_ISSUE;
        end else begin
          state_nxt = ST_ADDR_H;
        end
      end
      ST_ADDR_L: begin
        if (byte_done) begin
          state_nxt    = ST_DATA;
          phase_nxt    = PH_FETCH;
          data_rd_nxt  = 1'b1;
          byte_cnt_nxt = 9'd0;
        end else begin
          state_nxt = ST_ADDR_L;
        end
      end
      ST_DATA: begin
        if (byte_done) begin
          byte_cnt_nxt = byte_cnt + 9'd1;
          if (byte_cnt == BYTE_LAST) begin
            state_nxt      = ST_CS_GAP;
            gap_cnt_nxt    = 1'b0;
            gap_target_nxt = ST_POLL_CMD;
            ncs_nxt        = 1'b1;
          end else begin
            phase_nxt   = PH_FETCH;
            data_rd_nxt = 1'b1;
          end
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_POLL_CMD: begin
        if (byte_done) begin
          state_nxt = ST_POLL_RD;
          phase_nxt = PH_ISSUE;
        end else begin
          state_nxt = ST_POLL_CMD;
        end
      end
      ST_POLL_RD: begin
        if (byte_done) begin
          state_nxt = ST_CHECK;
          wip_nxt   = spi_rx[0];
          ncs_nxt   = 1'b1;
        end else begin
          state_nxt = ST_POLL_RD;
        end
      end
      // CHECK is also the first nCS-high cycle of the re-poll gap.
      ST_CHECK: begin
        if (!wip) begin
          state_nxt = ST_DONE;
          done_nxt  = grant;
        end else if (poll_cnt == POLL_LAST) begin
          state_nxt   = ST_DONE;
          done_nxt    = grant;
          timeout_nxt = 1'b1;
        end else begin
          poll_cnt_nxt   = poll_cnt + PW'(1);
          state_nxt      = ST_CS_GAP;
          gap_cnt_nxt    = 1'b1;
          gap_target_nxt = ST_POLL_CMD;
        end
      end
      ST_DONE: begin
        state_nxt  = ST_IDLE;
        grant_nxt  = 2'b00;
        arb_update = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = 2'b00;
        ncs_nxt   = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      phase      <= PH_SETUP;
      gap_cnt    <= 1'b0;
      gap_target <= ST_IDLE;
      byte_cnt   <= 9'd0;
      poll_cnt   <= '0;
      busy_seen  <= 1'b0;
      owner      <= 1'b0;
      page_addr  <= 16'h0000;
      wip        <= 1'b0;
      nCS        <= 1'b1;
      grant      <= 2'b00;
      done       <= 2'b00;
      timeout    <= 1'b0;
      data_rd    <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      gap_cnt    <= gap_cnt_nxt;
      gap_target <= gap_target_nxt;
      byte_cnt   <= byte_cnt_nxt;
      poll_cnt   <= poll_cnt_nxt;
      busy_seen  <= busy_seen_nxt;
      owner      <= owner_nxt;
      page_addr  <= page_addr_nxt;
      wip        <= wip_nxt;
      nCS        <= ncs_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      timeout    <= timeout_nxt;
      data_rd    <= data_rd_nxt;
    end
  end

endmodule

// File: doc/eeprom_page_sched.md
EEPROM_PAGE_SCHED -- requirements
Module: eeprom_page_sched

Interface
REQ-001 SHALL have parameter PAGE_BYTES, default 32, data bytes per page write (power of 2, 2..256).
REQ-002 SHALL have parameter POLL_MAX, default 1023, maximum RDSR polls before timeout.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  in  2  page-write request; bit0 logger buffer, bit1 config; level, held until done.
REQ-006 SHALL have ports addr0, addr1  in  16 each  page start address of requester 0/1.
REQ-007 SHALL have ports data_in0, data_in1  in  8 each  byte from requester 0/1.
REQ-008 SHALL have port data_rd  out  1  one-cycle pulse requesting the next byte from the granted requester.
REQ-009 SHALL have port grant  out  2  one-hot owner of the EEPROM, 0 when idle.
REQ-010 SHALL have port done  out  2  one-cycle completion pulse to the owner.
REQ-011 SHALL have port timeout  out  1  one-cycle pulse, together with done, when polling exceeds POLL_MAX.
REQ-012 SHALL have ports spi_start out 1, spi_tx out 8, spi_busy in 1, spi_rx in 8  byte-engine handshake.
REQ-013 SHALL have port nCS  out  1  EEPROM chip select, active low.

Function
REQ-014 SHALL, in IDLE with any req set, grant round-robin: the requester not granted last wins; simultaneous requests after reset go to requester 0.
REQ-015 SHALL latch the granted address with its low log2(PAGE_BYTES) bits forced to 0.
REQ-016 SHALL sequence: WREN(0x06), CS_GAP, WRITE(0x02), ADDR_H, ADDR_L, DATA x PAGE_BYTES, CS_GAP, POLL_CMD(0x05), POLL_RD(0x00 dummy), CHECK, DONE, IDLE.
REQ-017 SHALL pulse spi_start for one cycle only while spi_busy=0, with spi_tx valid that cycle.
REQ-018 SHALL treat the first cycle with spi_busy=0 after spi_busy was 1 as byte complete; spi_rx is sampled that cycle.
REQ-019 SHALL drive nCS low one cycle before the first byte of each transaction and high the cycle after its last byte completes.
REQ-020 SHALL hold nCS high for exactly 2 cycles in each CS_GAP, including between successive polls.
REQ-021 SHALL issue data_rd one cycle before the spi_start of each data byte and transmit the selected data_in sampled on the following cycle (latency 1).
REQ-022 SHALL count data bytes in an 8-bit-safe counter and leave DATA after exactly PAGE_BYTES bytes.
REQ-023 SHALL, in CHECK: if spi_rx[0]=0 (WIP clear) go to DONE; otherwise increment the poll count and re-poll via CS_GAP.
REQ-024 SHALL, when the poll count reaches POLL_MAX with WIP still set, pulse timeout with done and return to IDLE.
REQ-025 SHALL pulse done[owner] for one cycle in DONE, clear grant the next cycle, and record the owner for round-robin.
REQ-026 SHALL ignore req deassertion mid-transaction and complete the page.
REQ-027 SHALL ignore spi_busy pulses while no byte is outstanding.

Reset
REQ-028 SHALL, on rst=0 at any time including mid-transaction, force IDLE, nCS=1, spi_start=0, spi_tx=0, data_rd=0, grant=0, done=0, timeout=0, all counters 0, last-grant=requester 1.

Structure
REQ-029 SHALL take state encoding and SPI opcode constants (WREN 0x06, WRITE 0x02, RDSR 0x05) from the shared logger package.
REQ-030 SHALL instantiate one sub-module, rr_arb2, a two-requester round-robin arbiter with registered last-grant.

Verification
REQ-031 SHALL verify: req=01, addr0=0x1234, PAGE_BYTES=32 -> SPI bytes 06 | 02 12 20 + 32 data | 05 00, done=01 once, data_rd 32 pulses.
REQ-032 SHALL verify: req=11 after reset -> requester 0 serviced first, then requester 1 without re-request, done=01 then 10.
REQ-033 SHALL verify: spi_rx WIP=1 for 3 polls then 0 -> 4 RDSR transactions, each bracketed by a 2-cycle nCS-high gap, then done.
REQ-034 SHALL verify: WIP stuck 1, POLL_MAX=4 -> timeout and done pulse together after the 4th poll, grant cleared next cycle.
REQ-035 SHALL verify: rst=0 during the 10th data byte -> nCS=1 and grant=0 immediately; a fresh req restarts from WREN.
REQ-036 SHALL verify: spi_busy held 1 for 500 cycles on a byte -> no new spi_start until busy falls; byte order preserved.
